fir_mac_serial: RTL and testbench

Parametrised, time-multiplexed FIR filter: one signed multiplier and one accumulator evaluate a TAPS-tap convolution over TAPS clock cycles per input sample. It is the successor to the team's fixed 3-tap FIR and adds:
- configurable data, coefficient and output widths;
- configurable tap count;
- runtime-writable coefficients;
- valid/ready handshakes on input and output;
- rounding, scaling and output saturation.

It sits in the sample-rate-limited datapath, where clock rate is at least (TAPS+1) times the sample rate.

---
 rtl/fir_mac_serial_if.sv | 23 ++
 rtl/fir_mac_serial.sv | 138 +++++++++++++
 tb/tb_fir_mac_serial.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_serial_if.sv
// Sample, result and coefficient-write signals of fir_mac_serial.
interface fir_mac_serial_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned AW     = 3,
   parameter int unsigned OUT_W  = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     coef_we;
   logic        [AW-1:0]     coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic                     busy;

   modport master (output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
                   input  in_ready, out_valid, out_data, busy);
   modport slave  (input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
                   output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one multiplier and one accumulator walk TAPS taps per sample,
// then round, shift and saturate the sum into a held, handshaked result.
module fir_mac_serial #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned TAPS   = 8,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned SHIFT  = 0
) (
   input logic             clk,
   input logic             reset,
   fir_mac_serial_if.slave bus
);
   localparam int unsigned AW      = $clog2(TAPS);
   localparam int unsigned PW      = DATA_W + COEF_W;
   localparam int unsigned ACC_W   = PW + AW;
   localparam int unsigned RW      = ACC_W + 1;
   localparam int unsigned RND_POS = (SHIFT == 0) ? 0 : SHIFT - 1;
   localparam logic signed [RW-1:0] RND = (SHIFT == 0) ? RW'(0) : (RW'(1) << RND_POS);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                    state_q, state_d;
   logic signed [DATA_W-1:0]  x_q [TAPS];
   logic signed [DATA_W-1:0]  x_d [TAPS];
   logic signed [COEF_W-1:0]  c_q [TAPS];
   logic signed [COEF_W-1:0]  c_d [TAPS];
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic        [AW-1:0]      k_q, k_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]   out_data_q, out_data_d;

   logic signed [PW-1:0]      prod_c;
   logic signed [ACC_W-1:0]   sum_c;
   logic signed [RW-1:0]      rsum_c;
   logic signed [RW-1:0]      shr_c;
   logic signed [OUT_W-1:0]   sat_c;
   logic                      in_ready_c;
   logic                      accept_c;
   logic                      coef_ok_c;

   // Datapath: product of the current tap, running sum, round-half-up then arithmetic shift
   always_comb begin
      prod_c = PW'(c_q[k_q]) * PW'(x_q[k_q]);
      sum_c  = acc_q + ACC_W'(prod_c);
      rsum_c = RW'(sum_c) + RND;
      shr_c  = rsum_c >>> SHIFT;
   end

   if (OUT_W >= RW) begin : g_wide
      always_comb sat_c = OUT_W'(shr_c);
   end else begin : g_clamp
      localparam logic signed [RW-1:0] MAXV = RW'({1'b0, {(OUT_W-1){1'b1}}});
      localparam logic signed [RW-1:0] MINV = ~MAXV;
      always_comb begin
         if (shr_c > MAXV)      sat_c = OUT_W'(MAXV);
         else if (shr_c < MINV) sat_c = OUT_W'(MINV);
         else                   sat_c = OUT_W'(shr_c);
      end
   end

   always_comb begin
      in_ready_c = !reset && ((state_q == S_IDLE) || ((state_q == S_OUT) && bus.out_ready));
      accept_c   = bus.in_valid && in_ready_c;
      coef_ok_c  = (32'(bus.coef_addr) < TAPS);
   end

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      c_d         = c_q;
      acc_d       = acc_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         S_MAC: begin
            acc_d = sum_c;
            k_d   = k_q + AW'(1);
            if (k_q == AW'(TAPS - 1)) begin
               out_data_d  = sat_c;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: ;
      endcase

      // Acceptance is possible from IDLE or on the OUT handshake edge
      if (accept_c) begin
         x_d[0] = bus.in_data;
         for (int unsigned i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
         acc_d   = '0;
         k_d     = '0;
         state_d = S_MAC;
      end

      // Bank is frozen during MAC so a convolution never mixes coefficient sets
      if (bus.coef_we && coef_ok_c && (state_q != S_MAC)) c_d[bus.coef_addr] = bus.coef_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int unsigned i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= (i == 0) ? COEF_W'(1) : '0;
         end
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int unsigned i = 0; i < TAPS; i++) begin
            x_q[i] <= x_d[i];
            c_q[i] <= c_d[i];
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state_q == S_MAC);
endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench for fir_mac_serial: identity, loaded taps, saturation/rounding,
// back-pressure, coefficient-write hazards and reset mid-operation.
module tb_fir_mac_serial;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fir_mac_serial_if #(.DATA_W(8), .COEF_W(8), .AW(3), .OUT_W(16)) ia ();
   fir_mac_serial_if #(.DATA_W(8), .COEF_W(8), .AW(2), .OUT_W(16)) ib ();
   fir_mac_serial_if #(.DATA_W(8), .COEF_W(8), .AW(1), .OUT_W(8))  ic ();

   fir_mac_serial u_a (.clk(clk), .reset(reset), .bus(ia));
   fir_mac_serial #(.TAPS(3)) u_b (.clk(clk), .reset(reset), .bus(ib));
   fir_mac_serial #(.TAPS(2), .OUT_W(8), .SHIFT(2)) u_c (.clk(clk), .reset(reset), .bus(ic));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input int a, input int d);
      ia.coef_we = 1'b1; ia.coef_addr = 3'(a); ia.coef_data = 8'(d);
      tick();
      ia.coef_we = 1'b0;
   endtask

   task automatic wr_b(input int a, input int d);
      ib.coef_we = 1'b1; ib.coef_addr = 2'(a); ib.coef_data = 8'(d);
      tick();
      ib.coef_we = 1'b0;
   endtask

   task automatic wr_c(input int a, input int d);
      ic.coef_we = 1'b1; ic.coef_addr = 1'(a); ic.coef_data = 8'(d);
      tick();
      ic.coef_we = 1'b0;
   endtask

   // Present one sample, wait for acceptance, return cycles to out_valid and the result
   task automatic run_a(input int d, output int lat, output logic signed [15:0] q);
      int n = 0;
      lat = -1; q = 'x;
      ia.in_valid = 1'b1; ia.in_data = 8'(d);
      while (!ia.in_ready && n < 40) begin tick(); n++; end
      if (!ia.in_ready) begin ia.in_valid = 1'b0; return; end
      tick();
      ia.in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ia.out_valid) begin lat = i; q = ia.out_data; break; end
      end
   endtask

   task automatic run_b(input int d, output int lat, output logic signed [15:0] q);
      int n = 0;
      lat = -1; q = 'x;
      ib.in_valid = 1'b1; ib.in_data = 8'(d);
      while (!ib.in_ready && n < 40) begin tick(); n++; end
      if (!ib.in_ready) begin ib.in_valid = 1'b0; return; end
      tick();
      ib.in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ib.out_valid) begin lat = i; q = ib.out_data; break; end
      end
   endtask

   task automatic run_c(input int d, output int lat, output logic signed [7:0] q);
      int n = 0;
      lat = -1; q = 'x;
      ic.in_valid = 1'b1; ic.in_data = 8'(d);
      while (!ic.in_ready && n < 40) begin tick(); n++; end
      if (!ic.in_ready) begin ic.in_valid = 1'b0; return; end
      tick();
      ic.in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ic.out_valid) begin lat = i; q = ic.out_data; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ia.in_valid = 0; ia.in_data = 0; ia.coef_we = 0; ia.coef_addr = 0; ia.coef_data = 0; ia.out_ready = 1;
      ib.in_valid = 0; ib.in_data = 0; ib.coef_we = 0; ib.coef_addr = 0; ib.coef_data = 0; ib.out_ready = 1;
      ic.in_valid = 0; ic.in_data = 0; ic.coef_we = 0; ic.coef_addr = 0; ic.coef_data = 0; ic.out_ready = 1;
      repeat (3) tick();
      checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ia.out_valid); end
      checks++; if (ia.out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", ia.out_data); end
      checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b expected 0", ia.in_ready); end
      checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ia.busy); end
      checks++; if (ic.out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data_c: got %0d expected 0", ic.out_data); end
      reset = 1'b0;
      #1;
      checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_idle: got %b expected 1", ia.in_ready); end
      checks++; if (ib.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_idle_b: got %b expected 1", ib.in_ready); end
   endtask

   task automatic test_identity();
      int                 lat;
      logic signed [15:0] q;
      int                 ins [2] = '{5, -7};
      for (int i = 0; i < 2; i++) begin
         run_a(ins[i], lat, q);
         checks++; if (q !== 16'(ins[i])) begin errors++; $display("FAIL identity_data[%0d]: got %0d expected %0d", i, q, ins[i]); end
         checks++; if (lat !== 8) begin errors++; $display("FAIL identity_latency[%0d]: got %0d expected 8", i, lat); end
      end
   endtask

   task automatic test_coef_load();
      int                 lat;
      logic signed [15:0] q;
      int                 ins [9] = '{1, 2, 3, 0, 0, 0, 1, 0, 0};
      int                 exp [9] = '{1, 4, 8, 8, 3, 0, 1, 2, 1};
      wr_b(0, 1); wr_b(1, 2); wr_b(2, 1);
      for (int i = 0; i < 9; i++) begin
         run_b(ins[i], lat, q);
         checks++; if (q !== 16'(exp[i])) begin errors++; $display("FAIL coef_load[%0d]: got %0d expected %0d", i, q, exp[i]); end
         checks++; if (lat !== 3) begin errors++; $display("FAIL coef_load_latency[%0d]: got %0d expected 3", i, lat); end
      end
   endtask

   task automatic test_sat_round();
      int                lat;
      logic signed [7:0] q;
      int                sins [4] = '{127, 127, -128, -128};
      int                sexp [4] = '{127, 127, -32, -128};
      int                rins [6] = '{6, -6, 5, 2, -2, -7};
      int                rexp [6] = '{2, -1, 1, 1, 0, -2};
      wr_c(0, 127); wr_c(1, 127);
      for (int i = 0; i < 4; i++) begin
         run_c(sins[i], lat, q);
         checks++; if (q !== 8'(sexp[i])) begin errors++; $display("FAIL saturate[%0d]: got %0d expected %0d", i, q, sexp[i]); end
      end
      checks++; if (lat !== 2) begin errors++; $display("FAIL saturate_latency: got %0d expected 2", lat); end
      wr_c(0, 1); wr_c(1, 0);
      for (int i = 0; i < 6; i++) begin
         run_c(rins[i], lat, q);
         checks++; if (q !== 8'(rexp[i])) begin errors++; $display("FAIL round[%0d]: got %0d expected %0d", i, q, rexp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int                 lat = -1;
      int                 first_out = -1, restart = -1, second_out = -1;
      logic signed [15:0] q1 = 'x, q2 = 'x;
      logic               prev_busy = 1'b1;
      tick();
      ia.out_ready = 1'b0;
      ia.in_valid = 1'b1; ia.in_data = 8'sd11;
      tick();
      ia.in_data = 8'sd22;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ia.out_valid) begin lat = i; break; end
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (ia.out_valid !== 1'b1 || ia.out_data !== 16'sd11 || ia.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%0d in_ready=%b expected 1/11/0", i, ia.out_valid, ia.out_data, ia.in_ready);
         end
         tick();
      end
      ia.out_ready = 1'b1;
      #1;
      checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b expected 1", ia.in_ready); end
      tick();
      checks++; if (ia.busy !== 1'b1 || ia.out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake_accept: got busy=%b valid=%b expected 1/0", ia.busy, ia.out_valid); end
      ia.in_data = 8'sd33;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (ia.out_valid && first_out < 0) begin first_out = n; q1 = ia.out_data; end
         else if (ia.out_valid && restart > 0 && second_out < 0) begin second_out = n; q2 = ia.out_data; end
         if (ia.busy && !prev_busy && restart < 0) begin restart = n; ia.in_valid = 1'b0; end
         prev_busy = ia.busy;
         if (second_out > 0) break;
      end
      checks++; if (first_out !== 8) begin errors++; $display("FAIL stream_first_out: got %0d expected 8", first_out); end
      checks++; if (q1 !== 16'sd22) begin errors++; $display("FAIL stream_first_data: got %0d expected 22", q1); end
      checks++; if (restart !== 9) begin errors++; $display("FAIL stream_period: got %0d expected 9", restart); end
      checks++; if (second_out !== 17) begin errors++; $display("FAIL stream_second_out: got %0d expected 17", second_out); end
      checks++; if (q2 !== 16'sd33) begin errors++; $display("FAIL stream_second_data: got %0d expected 33", q2); end
   endtask

   task automatic test_coef_hazard();
      int                 lat;
      logic signed [15:0] q = 'x;
      tick();
      // Write c[0]=5 while the sample 4 is in MAC; must be dropped
      ib.in_valid = 1'b1; ib.in_data = 8'sd4;
      tick();
      ib.in_valid = 1'b0;
      ib.coef_we = 1'b1; ib.coef_addr = 2'd0; ib.coef_data = 8'sd5;
      tick();
      ib.coef_we = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ib.out_valid) begin q = ib.out_data; break; end
         tick();
      end
      checks++; if (q !== 16'sd4) begin errors++; $display("FAIL hazard_mac_result: got %0d expected 4", q); end
      wr_b(3, 7);
      run_b(2, lat, q);
      checks++; if (q !== 16'sd10) begin errors++; $display("FAIL hazard_bank_kept: got %0d expected 10", q); end
      tick();
      // Write c[0]=3 while parked in OUT; next sample must use it
      ib.out_ready = 1'b0;
      ib.in_valid = 1'b1; ib.in_data = 8'sd1;
      tick();
      ib.in_valid = 1'b0;
      q = 'x;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ib.out_valid) begin q = ib.out_data; break; end
      end
      checks++; if (q !== 16'sd9) begin errors++; $display("FAIL hazard_pre_out: got %0d expected 9", q); end
      wr_b(0, 3);
      checks++; if (ib.out_valid !== 1'b1 || ib.out_data !== 16'sd9) begin errors++; $display("FAIL hazard_out_hold: got valid=%b data=%0d expected 1/9", ib.out_valid, ib.out_data); end
      ib.out_ready = 1'b1;
      tick();
      run_b(1, lat, q);
      checks++; if (q !== 16'sd7) begin errors++; $display("FAIL hazard_write_in_out: got %0d expected 7", q); end
   endtask

   task automatic test_reset_mid();
      int                 lat;
      int                 seen = 0;
      logic signed [15:0] q;
      tick();
      wr_a(0, 2);
      ia.in_valid = 1'b1; ia.in_data = 8'sd50;
      tick();
      ia.in_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      #1;
      checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", ia.busy); end
      checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b expected 0", ia.in_ready); end
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (ia.out_valid) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_out: got %0d valid cycles expected 0", seen); end
      // c[1]=1 exposes any stale delay-line entry; c[0] must be back to 1
      wr_a(1, 1);
      run_a(9, lat, q);
      checks++; if (q !== 16'sd9) begin errors++; $display("FAIL midreset_restore: got %0d expected 9", q); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL midreset_latency: got %0d expected 8", lat); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_identity();
      test_coef_load();
      test_sat_round();
      test_back_to_back();
      test_coef_hazard();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
